// File: rtl/mbssoc_rr_mem_arbiter.sv
// mbssoc_rr_mem_arbiter
//   Round-robin sequencer sharing one single-port RAM among CORE_NUM cores.
//   A winner is chosen in IDLE, its read/write/address are latched and held
//   on the RAM for ACCESS_CYC cycles, then ack pulses and ownership returns.
//   The most recently served core gets the lowest priority next time.
//   Optional feature macro: MBSSOC_ARB_LOCK_EN adds req_lock and a LOCKED
//   state so one core can keep the RAM across back-to-back accesses.
module mbssoc_rr_mem_arbiter #(
    parameter int CORE_NUM   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int ACCESS_CYC = 1,
    parameter int ID_WIDTH   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CORE_NUM-1:0]            req_re,
    input  logic [CORE_NUM-1:0]            req_we,
    input  logic [CORE_NUM*ADDR_WIDTH-1:0] req_addr,
`ifdef MBSSOC_ARB_LOCK_EN
    input  logic [CORE_NUM-1:0]            req_lock,
`endif
    output logic                           ram_re,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic                           grant_valid,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic [CORE_NUM-1:0]            ack,
    output logic [CORE_NUM-1:0]            cpu_pause
);

    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef MBSSOC_ARB_LOCK_EN
        ST_LOCKED = 2'd2,
`endif
        ST_ACCESS = 2'd1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ID_WIDTH-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [ID_WIDTH-1:0]     grant_id_reg, grant_id_next;
    logic                    grant_valid_reg, grant_valid_next;
    logic                    ram_re_reg, ram_re_next;
    logic                    ram_we_reg, ram_we_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg, ram_addr_next;

    logic [CORE_NUM-1:0]     req_vec;
    logic [ID_WIDTH-1:0]     winner;
    logic                    win_found;
    int                      scan_idx;
    logic [ID_WIDTH-1:0]     sel_id;
    logic                    sel_re, sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    last_beat;

    assign last_beat = (state_reg == ST_ACCESS) && (cnt_reg == CNT_W'(ACCESS_CYC - 1));

    // Per-core request, completion pulse and stall
    genvar gi;
    generate
        for (gi = 0; gi < CORE_NUM; gi++) begin : g_core
            assign req_vec[gi]   = req_re[gi] | req_we[gi];
            assign ack[gi]       = last_beat && (grant_id_reg == ID_WIDTH'(gi));
            assign cpu_pause[gi] = req_vec[gi] & ~ack[gi];
        end
    endgenerate

    // Rotating priority scan starting just after the last served core
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= CORE_NUM; k++) begin
            scan_idx = (int'(rr_ptr_reg) + k) % CORE_NUM;
            if (!win_found && req_vec[scan_idx]) begin
                winner    = ID_WIDTH'(scan_idx);
                win_found = 1'b1;
            end
        end
    end

    // Request fields of the core about to be presented; write wins over read
    always_comb begin
        sel_id   = (state_reg == ST_IDLE) ? winner : grant_id_reg;
        sel_we   = req_we[sel_id];
        sel_re   = req_re[sel_id] & ~req_we[sel_id];
        sel_addr = req_addr[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Next-state logic for the grant sequencer
    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        cnt_next         = cnt_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        ram_re_next      = ram_re_reg;
        ram_we_next      = ram_we_reg;
        ram_addr_next    = ram_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next       = ST_ACCESS;
                    grant_id_next    = winner;
                    grant_valid_next = 1'b1;
                    cnt_next         = '0;
                    ram_re_next      = sel_re;
                    ram_we_next      = sel_we;
                    ram_addr_next    = sel_addr;
                end
            end
            ST_ACCESS: begin
                if (last_beat) begin
                    cnt_next      = '0;
                    ram_re_next   = 1'b0;
                    ram_we_next   = 1'b0;
                    ram_addr_next = '0;
`ifdef MBSSOC_ARB_LOCK_EN
                    if (req_lock[grant_id_reg]) begin
                        state_next = ST_LOCKED;
                    end else begin
                        state_next       = ST_IDLE;
                        grant_valid_next = 1'b0;
                        rr_ptr_next      = grant_id_reg;
                    end
`else
                    state_next       = ST_IDLE;
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = grant_id_reg;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef MBSSOC_ARB_LOCK_EN
            ST_LOCKED: begin
                if (req_vec[grant_id_reg]) begin
                    state_next    = ST_ACCESS;
                    cnt_next      = '0;
                    ram_re_next   = sel_re;
                    ram_we_next   = sel_we;
                    ram_addr_next = sel_addr;
                end else if (!req_lock[grant_id_reg]) begin
                    state_next       = ST_IDLE;
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = grant_id_reg;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // State and RAM-side registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= ID_WIDTH'(CORE_NUM - 1);
            cnt_reg         <= '0;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
            ram_re_reg      <= 1'b0;
            ram_we_reg      <= 1'b0;
            ram_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            cnt_reg         <= cnt_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            ram_re_reg      <= ram_re_next;
            ram_we_reg      <= ram_we_next;
            ram_addr_reg    <= ram_addr_next;
        end
    end

    assign ram_re      = ram_re_reg;
    assign ram_we      = ram_we_reg;
    assign ram_addr    = ram_addr_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_mbssoc_rr_mem_arbiter.sv
// Testbench for mbssoc_rr_mem_arbiter: table-driven vectors on a 2-core,
// single-cycle instance plus hand sequences on a 3-cycle instance (reset
// abort) and, with MBSSOC_ARB_LOCK_EN, the locked back-to-back case.
module tb_mbssoc_rr_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: ACCESS_CYC = 1
    logic        rst_a;
    logic [1:0]  re_a, we_a;
    logic [63:0] addr_a;
    logic        ram_re_a, ram_we_a, gv_a;
    logic [31:0] ram_addr_a;
    logic [0:0]  gid_a;
    logic [1:0]  ack_a, pause_a;
`ifdef MBSSOC_ARB_LOCK_EN
    logic [1:0]  lock_a;
    logic [1:0]  lock_c;
`endif

    // Instance C: ACCESS_CYC = 3
    logic        rst_c;
    logic [1:0]  re_c, we_c;
    logic [63:0] addr_c;
    logic        ram_re_c, ram_we_c, gv_c;
    logic [31:0] ram_addr_c;
    logic [0:0]  gid_c;
    logic [1:0]  ack_c, pause_c;

    mbssoc_rr_mem_arbiter #(.CORE_NUM(2), .ADDR_WIDTH(32), .ACCESS_CYC(1), .ID_WIDTH(1)) dut_a (
        .clk(clk), .rst(rst_a), .req_re(re_a), .req_we(we_a), .req_addr(addr_a),
`ifdef MBSSOC_ARB_LOCK_EN
        .req_lock(lock_a),
`endif
        .ram_re(ram_re_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
        .grant_valid(gv_a), .grant_id(gid_a), .ack(ack_a), .cpu_pause(pause_a)
    );

    mbssoc_rr_mem_arbiter #(.CORE_NUM(2), .ADDR_WIDTH(32), .ACCESS_CYC(3), .ID_WIDTH(1)) dut_c (
        .clk(clk), .rst(rst_c), .req_re(re_c), .req_we(we_c), .req_addr(addr_c),
`ifdef MBSSOC_ARB_LOCK_EN
        .req_lock(lock_c),
`endif
        .ram_re(ram_re_c), .ram_we(ram_we_c), .ram_addr(ram_addr_c),
        .grant_valid(gv_c), .grant_id(gid_c), .ack(ack_c), .cpu_pause(pause_c)
    );

    typedef struct {
        logic [1:0]  re;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        e_re;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_gv;
        logic        e_gid;
        logic [1:0]  e_ack;
        logic [1:0]  e_pause;
    } vec_t;

    vec_t tbl[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic e_re, input logic e_we,
                           input logic [31:0] e_addr, input logic e_gv, input logic e_gid,
                           input logic [1:0] e_ack, input logic [1:0] e_pause);
        chk({tag, ".ram_re"},    32'(ram_re_a),  32'(e_re));
        chk({tag, ".ram_we"},    32'(ram_we_a),  32'(e_we));
        chk({tag, ".ram_addr"},  ram_addr_a,     e_addr);
        chk({tag, ".grant_vld"}, 32'(gv_a),      32'(e_gv));
        if (e_gv) chk({tag, ".grant_id"}, 32'(gid_a), 32'(e_gid));
        chk({tag, ".ack"},       32'(ack_a),     32'(e_ack));
        chk({tag, ".cpu_pause"}, 32'(pause_a),   32'(e_pause));
        $display("%s: re=%b we=%b addr=0x%0h gv=%b gid=%0d ack=%b pause=%b",
                 tag, ram_re_a, ram_we_a, ram_addr_a, gv_a, gid_a, ack_a, pause_a);
    endtask

    task automatic check_c(input string tag, input logic e_re, input logic [31:0] e_addr,
                           input logic e_gv, input logic [1:0] e_ack, input logic [1:0] e_pause);
        chk({tag, ".ram_re"},    32'(ram_re_c), 32'(e_re));
        chk({tag, ".ram_we"},    32'(ram_we_c), 32'd0);
        chk({tag, ".ram_addr"},  ram_addr_c,    e_addr);
        chk({tag, ".grant_vld"}, 32'(gv_c),     32'(e_gv));
        if (e_gv) chk({tag, ".grant_id"}, 32'(gid_c), 32'd0);
        chk({tag, ".ack"},       32'(ack_c),    32'(e_ack));
        chk({tag, ".cpu_pause"}, 32'(pause_c),  32'(e_pause));
        $display("%s: re=%b addr=0x%0h gv=%b ack=%b pause=%b",
                 tag, ram_re_c, ram_addr_c, gv_c, ack_c, pause_c);
    endtask

    function automatic vec_t mk(input logic [1:0] re, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic e_re, input logic e_we, input logic [31:0] e_addr,
                                input logic e_gv, input logic e_gid,
                                input logic [1:0] e_ack, input logic [1:0] e_pause);
        vec_t v;
        v.re = re; v.we = we; v.a0 = a0; v.a1 = a1;
        v.e_re = e_re; v.e_we = e_we; v.e_addr = e_addr; v.e_gv = e_gv;
        v.e_gid = e_gid; v.e_ack = e_ack; v.e_pause = e_pause;
        return v;
    endfunction

    initial begin
        // Single request, two-core write race, then alternating re-requests
        tbl[0]  = mk(2'b10, 2'b00, 32'h0,   32'h40,  0, 0, 32'h0,   0, 0, 2'b00, 2'b10);
        tbl[1]  = mk(2'b10, 2'b00, 32'h0,   32'h40,  1, 0, 32'h40,  1, 1, 2'b10, 2'b00);
        tbl[2]  = mk(2'b00, 2'b00, 32'h0,   32'h0,   0, 0, 32'h0,   0, 0, 2'b00, 2'b00);
        tbl[3]  = mk(2'b00, 2'b11, 32'h10,  32'h20,  0, 0, 32'h0,   0, 0, 2'b00, 2'b11);
        tbl[4]  = mk(2'b00, 2'b11, 32'h10,  32'h20,  0, 1, 32'h10,  1, 0, 2'b01, 2'b10);
        tbl[5]  = mk(2'b00, 2'b10, 32'h10,  32'h20,  0, 0, 32'h0,   0, 0, 2'b00, 2'b10);
        tbl[6]  = mk(2'b00, 2'b10, 32'h10,  32'h20,  0, 1, 32'h20,  1, 1, 2'b10, 2'b00);
        tbl[7]  = mk(2'b11, 2'b00, 32'h100, 32'h104, 0, 0, 32'h0,   0, 0, 2'b00, 2'b11);
        tbl[8]  = mk(2'b11, 2'b00, 32'h100, 32'h104, 1, 0, 32'h100, 1, 0, 2'b01, 2'b10);
        tbl[9]  = mk(2'b11, 2'b00, 32'h108, 32'h104, 0, 0, 32'h0,   0, 0, 2'b00, 2'b11);
        tbl[10] = mk(2'b11, 2'b00, 32'h108, 32'h104, 1, 0, 32'h104, 1, 1, 2'b10, 2'b01);
        tbl[11] = mk(2'b11, 2'b00, 32'h108, 32'h10C, 0, 0, 32'h0,   0, 0, 2'b00, 2'b11);
        tbl[12] = mk(2'b11, 2'b00, 32'h108, 32'h10C, 1, 0, 32'h108, 1, 0, 2'b01, 2'b10);
        tbl[13] = mk(2'b11, 2'b01, 32'h200, 32'h10C, 0, 0, 32'h0,   0, 0, 2'b00, 2'b11);
        tbl[14] = mk(2'b11, 2'b01, 32'h200, 32'h10C, 1, 0, 32'h10C, 1, 1, 2'b10, 2'b01);
        tbl[15] = mk(2'b01, 2'b01, 32'h200, 32'h10C, 0, 0, 32'h0,   0, 0, 2'b00, 2'b01);
        tbl[16] = mk(2'b01, 2'b01, 32'h200, 32'h10C, 0, 1, 32'h200, 1, 0, 2'b01, 2'b00);
        tbl[17] = mk(2'b00, 2'b00, 32'h0,   32'h0,   0, 0, 32'h0,   0, 0, 2'b00, 2'b00);

        rst_a = 1'b1; re_a = '0; we_a = '0; addr_a = '0;
        rst_c = 1'b1; re_c = '0; we_c = '0; addr_c = '0;
`ifdef MBSSOC_ARB_LOCK_EN
        lock_a = '0; lock_c = '0;
`endif
        step();
        step();
        rst_a = 1'b0;
        rst_c = 1'b0;

        // Idle after reset: everything quiet for 10 cycles
        for (int i = 0; i < 10; i++) begin
            #3;
            check_a($sformatf("idle_a[%0d]", i), 0, 0, 32'h0, 0, 0, 2'b00, 2'b00);
            chk($sformatf("idle_c[%0d].gv", i), 32'(gv_c), 32'd0);
            step();
        end

        // Table vectors on instance A
        for (int i = 0; i < 18; i++) begin
            re_a   = tbl[i].re;
            we_a   = tbl[i].we;
            addr_a = {tbl[i].a1, tbl[i].a0};
            #3;
            check_a($sformatf("vec[%0d]", i), tbl[i].e_re, tbl[i].e_we, tbl[i].e_addr,
                    tbl[i].e_gv, tbl[i].e_gid, tbl[i].e_ack, tbl[i].e_pause);
            step();
        end

        // Three-cycle access on instance C, full completion
        re_c = 2'b01; addr_c = {32'h0, 32'h80};
        #3; check_c("c3_req",  0, 32'h0,  0, 2'b00, 2'b01); step();
        #3; check_c("c3_cnt0", 1, 32'h80, 1, 2'b00, 2'b01); step();
        #3; check_c("c3_cnt1", 1, 32'h80, 1, 2'b00, 2'b01); step();
        #3; check_c("c3_cnt2", 1, 32'h80, 1, 2'b01, 2'b00); step();
        re_c = 2'b00;
        #3; check_c("c3_done", 0, 32'h0,  0, 2'b00, 2'b00); step();

        // Reset during cnt==1 aborts the access without ack, then re-grant
        re_c = 2'b01; addr_c = {32'h0, 32'h90};
        #3; check_c("rs_req",  0, 32'h0,  0, 2'b00, 2'b01); step();
        #3; check_c("rs_cnt0", 1, 32'h90, 1, 2'b00, 2'b01); step();
        rst_c = 1'b1;
        #3; check_c("rs_cnt1", 1, 32'h90, 1, 2'b00, 2'b01); step();
        rst_c = 1'b0;
        #3; check_c("rs_abort", 0, 32'h0, 0, 2'b00, 2'b01); step();
        #3; check_c("rs_cnt0b", 1, 32'h90, 1, 2'b00, 2'b01); step();
        #3; check_c("rs_cnt1b", 1, 32'h90, 1, 2'b00, 2'b01); step();
        #3; check_c("rs_cnt2b", 1, 32'h90, 1, 2'b01, 2'b00); step();
        re_c = 2'b00;
        #3; check_c("rs_done", 0, 32'h0,  0, 2'b00, 2'b00); step();

`ifdef MBSSOC_ARB_LOCK_EN
        // Locked owner: three back-to-back core0 reads before core1 is served
        rst_a = 1'b1; re_a = '0; we_a = '0; lock_a = '0;
        step();
        rst_a = 1'b0;
        re_a = 2'b11; lock_a = 2'b01; addr_a = {32'h400, 32'h300};
        #3; check_a("lk0", 0, 0, 32'h0,   0, 0, 2'b00, 2'b11); step();
        #3; check_a("lk1", 1, 0, 32'h300, 1, 0, 2'b01, 2'b10); step();
        addr_a = {32'h400, 32'h304};
        #3; check_a("lk2", 0, 0, 32'h0,   1, 0, 2'b00, 2'b11); step();
        #3; check_a("lk3", 1, 0, 32'h304, 1, 0, 2'b01, 2'b10); step();
        addr_a = {32'h400, 32'h308};
        #3; check_a("lk4", 0, 0, 32'h0,   1, 0, 2'b00, 2'b11); step();
        #3; check_a("lk5", 1, 0, 32'h308, 1, 0, 2'b01, 2'b10); step();
        re_a = 2'b10; lock_a = 2'b00;
        #3; check_a("lk6", 0, 0, 32'h0,   1, 0, 2'b00, 2'b10); step();
        #3; check_a("lk7", 0, 0, 32'h0,   0, 0, 2'b00, 2'b10); step();
        #3; check_a("lk8", 1, 0, 32'h400, 1, 1, 2'b10, 2'b00); step();
        re_a = 2'b00;
        #3; check_a("lk9", 0, 0, 32'h0,   0, 0, 2'b00, 2'b00); step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
